imem_rom_arbiter: RTL and testbench
===================================

Name: imem_rom_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the pipeline fetch stage and a debug/UART read-back port.
- Issues one ROM address per cycle and registers the ROM output, so read data returns with 1-cycle latency.
- Fetch has priority. A starvation counter forces debug bursts through so UART program dumps always make progress.
- Sits between the fetch stage / UART debug engine and the instruction ROM.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDR_WIDTH, 8, ROM address width.
- MAX_WAIT, 16, consecutive cycles debug may be starved before a forced grant (2..255).
- DBG_BURST, 4, maximum consecutive debug grants per won arbitration (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_WIDTH  fetch word address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_stall  out  1  fetch_req & ~fetch_gnt.
- fetch_valid  out  1  fetch_data valid.
- fetch_data  out  DATA_WIDTH  fetch read data.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_WIDTH  debug word address.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_valid  out  1  dbg_data valid.
- dbg_data  out  DATA_WIDTH  debug read data.
- rom_addr  out  ADDR_WIDTH  address to ROM.
- rom_q  in  DATA_WIDTH  combinational ROM output.

Behaviour:
- Reset (async, reset=0):
  - state=S_FETCH.
  - wait_cnt=0, burst_cnt=0.
  - fetch_valid=0, dbg_valid=0, fetch_data=0, dbg_data=0.
  - Grants are 0 while reset is asserted.
- Requests: a requester holds req and addr stable until it sees gnt. gnt is combinational from the current state and the req inputs; at most one gnt per cycle.
- rom_addr:
  - dbg_addr when dbg_gnt, otherwise fetch_addr.
  - When idle it still drives fetch_addr, so no X reaches the ROM.
- Read return:
  - On a grant edge, rom_q is captured into the granted side's *_data register and that side's *_valid is set for exactly 1 cycle.
  - The other side's data register holds its last value.
- S_FETCH:
  - fetch_gnt = fetch_req.
  - dbg_gnt = dbg_req & ~fetch_req.
  - wait_cnt increments while dbg_req & fetch_req, saturating at MAX_WAIT; it clears whenever dbg is granted or dbg_req=0.
  - wait_cnt==MAX_WAIT & dbg_req -> S_DBG next cycle, burst_cnt=0.
  - dbg_gnt in S_FETCH does not enter S_DBG.
- S_DBG:
  - dbg_gnt = dbg_req; fetch_gnt = 0, and fetch_stall follows fetch_req.
  - burst_cnt increments per debug grant.
  - Return to S_FETCH and clear wait_cnt when dbg_req=0 or burst_cnt reaches DBG_BURST-1 on a grant.
- Simultaneous first requests in S_FETCH: fetch wins.
- Addresses are taken modulo 2**ADDR_WIDTH; no range checking.
- Reset mid-burst: all state clears immediately, and any pending valid is dropped.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- Enabled: adds outputs stall_count[15:0] and forced_count[7:0].
  - stall_count counts cycles with fetch_stall=1.
  - forced_count counts S_FETCH->S_DBG transitions.
  - Both saturate at all-ones and reset to 0.
- Disabled: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Fetch only: fetch_req=1 with fetch_addr 0,1,2 on consecutive cycles, ROM preloaded with rom[i]=i+0x100 -> fetch_gnt=1 every cycle; fetch_valid one cycle later with data 0x100,0x101,0x102; dbg_valid=0 throughout.
- Debug idle slot: fetch_req=0, dbg_req=1, dbg_addr=0x20 -> dbg_gnt same cycle; dbg_data=rom[0x20] with dbg_valid=1 next cycle; state stays S_FETCH.
- Starvation: fetch_req=1 continuously, dbg_req=1 held, MAX_WAIT=16, DBG_BURST=4 -> after 16 starved cycles, 4 consecutive dbg_gnt with fetch_stall=1; then fetch resumes; pattern repeats every 20 cycles.
- Burst early exit: in S_DBG, drop dbg_req after 2 grants -> return to S_FETCH next cycle, fetch_gnt=1, wait_cnt=0.
- Async reset mid-burst: assert reset low during the S_DBG 2nd grant, not on a clock edge -> all valids and data=0 immediately; after release, first fetch_req granted in S_FETCH.
- Stats (IMEM_ARB_STATS_EN): repeat the starvation test for 40 cycles -> forced_count=2, stall_count=8.

Source files
------------

// File: rtl/imem_rom_arbiter.sv
// Arbitrates the single-port instruction ROM between fetch and debug read-back.
// Optional IMEM_ARB_STATS_EN adds saturating stall and forced-grant counters.
module imem_rom_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned DBG_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef IMEM_ARB_STATS_EN
  output logic [15:0]           stall_count,
  output logic [7:0]            forced_count,
`endif
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam logic S_FETCH = 1'b0;
  localparam logic S_DBG   = 1'b1;

  logic                  state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d, wait_inc;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  dbg_valid_q, dbg_valid_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;

  // Grants are suppressed while reset is held so nothing is launched mid-reset.
  always_comb begin
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    if (reset) begin
      if (state_q == S_FETCH) begin
        fetch_gnt = fetch_req;
        dbg_gnt   = dbg_req & ~fetch_req;
      end else begin
        dbg_gnt = dbg_req;
      end
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign rom_addr    = dbg_gnt ? dbg_addr : fetch_addr;
  assign wait_inc    = (wait_cnt_q == 8'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 8'd1;

  // Forced burst starts once debug has been starved for MAX_WAIT cycles.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (dbg_req && fetch_req) begin
          wait_cnt_d = wait_inc;
          if (wait_inc == 8'(MAX_WAIT)) begin
            state_d     = S_DBG;
            wait_cnt_d  = 8'd0;
            burst_cnt_d = 4'd0;
          end
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        wait_cnt_d = 8'd0;
        if (!dbg_req) begin
          state_d = S_FETCH;
        end else if (burst_cnt_q == 4'(DBG_BURST - 1)) begin
          state_d     = S_FETCH;
          burst_cnt_d = 4'd0;
        end else begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    fetch_valid_d = fetch_gnt;
    dbg_valid_d   = dbg_gnt;
    fetch_data_d  = fetch_gnt ? rom_q : fetch_data_q;
    dbg_data_d    = dbg_gnt ? rom_q : dbg_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= 8'd0;
      burst_cnt_q   <= 4'd0;
      fetch_valid_q <= 1'b0;
      dbg_valid_q   <= 1'b0;
      fetch_data_q  <= '0;
      dbg_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      dbg_valid_q   <= dbg_valid_d;
      fetch_data_q  <= fetch_data_d;
      dbg_data_q    <= dbg_data_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign dbg_valid   = dbg_valid_q;
  assign fetch_data  = fetch_data_q;
  assign dbg_data    = dbg_data_q;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [7:0]  forced_count_q, forced_count_d;

  always_comb begin
    stall_count_d  = stall_count_q;
    forced_count_d = forced_count_q;
    if (fetch_stall && (stall_count_q != 16'hffff)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if ((state_q == S_FETCH) && (state_d == S_DBG) && (forced_count_q != 8'hff)) begin
      forced_count_d = forced_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q  <= 16'd0;
      forced_count_q <= 8'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      forced_count_q <= forced_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign forced_count = forced_count_q;
`endif

endmodule

// File: tb/tb_imem_rom_arbiter.sv
// Self-checking bench for imem_rom_arbiter: directed vectors plus a per-cycle reference model.
// Stats checks are compiled in when IMEM_ARB_STATS_EN is defined.
module tb_imem_rom_arbiter;

  localparam int MAX_WAIT  = 16;
  localparam int DBG_BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req, dbg_req;
  logic [7:0]  fetch_addr, dbg_addr, rom_addr;
  logic        fetch_gnt, fetch_stall, fetch_valid, dbg_gnt, dbg_valid;
  logic [31:0] fetch_data, dbg_data, rom_q;
  logic [31:0] rom [256];
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_count;
  logic [7:0]  forced_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_q = rom[rom_addr];

  imem_rom_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_WAIT(MAX_WAIT), .DBG_BURST(DBG_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef IMEM_ARB_STATS_EN
    .stall_count (stall_count),
    .forced_count(forced_count),
`endif
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_gnt     (dbg_gnt),
    .dbg_valid   (dbg_valid),
    .dbg_data    (dbg_data),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: debug owes a number of forced grants after MAX_WAIT starved cycles.
  int          m_starve = 0;
  int          m_forced_left = 0;
  logic        m_fv = 1'b0, m_dv = 1'b0;
  logic [31:0] m_fd = '0, m_dd = '0;
  int          m_stall = 0, m_forced = 0;
  logic        e_fgnt, e_dgnt;

  always_comb begin
    e_fgnt = 1'b0;
    e_dgnt = 1'b0;
    if (reset === 1'b1) begin
      if (m_forced_left > 0) begin
        e_dgnt = dbg_req;
      end else begin
        e_fgnt = fetch_req;
        e_dgnt = dbg_req & ~fetch_req;
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_starve <= 0; m_forced_left <= 0; m_fv <= 1'b0; m_dv <= 1'b0;
      m_fd <= '0; m_dd <= '0; m_stall <= 0; m_forced <= 0;
    end else begin
      m_fv <= e_fgnt;
      m_dv <= e_dgnt;
      if (e_fgnt) m_fd <= rom[fetch_addr];
      if (e_dgnt) m_dd <= rom[dbg_addr];
      if (fetch_req && !e_fgnt && m_stall < 65535) m_stall <= m_stall + 1;
      if (m_forced_left > 0) begin
        m_forced_left <= dbg_req ? m_forced_left - 1 : 0;
        m_starve <= 0;
      end else if (dbg_req && fetch_req) begin
        if (m_starve + 1 == MAX_WAIT) begin
          m_forced_left <= DBG_BURST;
          m_starve <= 0;
          if (m_forced < 255) m_forced <= m_forced + 1;
        end else begin
          m_starve <= m_starve + 1;
        end
      end else begin
        m_starve <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_fetch_gnt", fetch_gnt, e_fgnt);
    check("cmp_dbg_gnt", dbg_gnt, e_dgnt);
    check("cmp_fetch_stall", fetch_stall, fetch_req & ~e_fgnt);
    check("cmp_rom_addr", rom_addr, e_dgnt ? dbg_addr : fetch_addr);
    check("cmp_fetch_valid", fetch_valid, m_fv);
    check("cmp_dbg_valid", dbg_valid, m_dv);
    check("cmp_fetch_data", fetch_data, m_fd);
    check("cmp_dbg_data", dbg_data, m_dd);
`ifdef IMEM_ARB_STATS_EN
    check("cmp_stall_count", stall_count, 64'(m_stall));
    check("cmp_forced_count", forced_count, 64'(m_forced));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [39:0] dmask, smask;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h100 + i;
    fetch_req = 1'b1; fetch_addr = 8'd0; dbg_req = 1'b1; dbg_addr = 8'd0;
    #1 reset = 1'b0;
    #2;
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_dbg_valid", dbg_valid, 0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_dbg_data", dbg_data, 0);
    fetch_req = 1'b0; dbg_req = 1'b0;
    #9 reset = 1'b1;
    step();

    // Fetch only, back-to-back
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'(i);
      #1;
      check("fo_gnt", fetch_gnt, 1);
      check("fo_dbg_valid", dbg_valid, 0);
      step();
      check("fo_valid", fetch_valid, 1);
      check("fo_data", fetch_data, 32'h100 + i);
    end
    fetch_req = 1'b0;
    step();
    check("fo_valid_drop", fetch_valid, 0);

    // Debug in an idle slot
    dbg_req = 1'b1; dbg_addr = 8'h20;
    #1;
    check("di_gnt", dbg_gnt, 1);
    check("di_rom_addr", rom_addr, 8'h20);
    step();
    dbg_req = 1'b0;
    check("di_valid", dbg_valid, 1);
    check("di_data", dbg_data, 32'h120);
    check("di_fetch_valid", fetch_valid, 0);
    step();
    check("di_valid_pulse", dbg_valid, 0);
    check("di_data_hold", dbg_data, 32'h120);

    // Starvation: 16 fetch cycles then 4 forced debug grants, period 20
    dbg_addr = 8'h30;
    for (int c = 0; c < 40; c++) begin
      fetch_req = 1'b1; dbg_req = 1'b1; fetch_addr = 8'(c);
      #1;
      dmask[c] = dbg_gnt;
      smask[c] = fetch_stall;
      step();
    end
    check("sv_dbg_gnt_mask", dmask, 40'hF0000F0000);
    check("sv_stall_mask", smask, 40'hF0000F0000);
    check("sv_dbg_data", dbg_data, 32'h130);
`ifdef IMEM_ARB_STATS_EN
    check("st_forced_count", forced_count, 2);
    check("st_stall_count", stall_count, 8);
`endif
    fetch_req = 1'b0; dbg_req = 1'b0;
    step();

    // Burst early exit after 2 grants
    for (int c = 0; c < 18; c++) begin
      fetch_req = 1'b1; dbg_req = 1'b1;
      #1;
      check("ee_dbg_gnt", dbg_gnt, (c >= 16) ? 1 : 0);
      step();
    end
    dbg_req = 1'b0;
    #1;
    check("ee_last_fetch_gnt", fetch_gnt, 0);
    check("ee_last_stall", fetch_stall, 1);
    step();
    check("ee_resume_gnt", fetch_gnt, 1);

    // Wait counter restarted from zero; then reset lands on the 2nd forced grant
    for (int c = 0; c < 17; c++) begin
      fetch_req = 1'b1; dbg_req = 1'b1;
      #1;
      check("rb_dbg_gnt", dbg_gnt, (c == 16) ? 1 : 0);
      step();
    end
    #1;
    check("rb_second_gnt", dbg_gnt, 1);
    check("rb_valid_before", dbg_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("rb_dbg_valid", dbg_valid, 0);
    check("rb_dbg_data", dbg_data, 0);
    check("rb_fetch_valid", fetch_valid, 0);
    check("rb_fetch_data", fetch_data, 0);
    check("rb_dbg_gnt_rst", dbg_gnt, 0);
    #2 reset = 1'b1;
    #1;
    dbg_req = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd5;
    #1;
    check("rb_fetch_gnt", fetch_gnt, 1);
    step();
    check("rb_fetch_valid_after", fetch_valid, 1);
    check("rb_fetch_data_after", fetch_data, 32'h105);
    fetch_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
